// File: rtl/tpu_pkg.sv
// Shared parameters and types for the tpumac datapath blocks (skew buffers,
// MAC array, operand memories).
package tpu_pkg;

   localparam int BITS_AB_DEF = 8;
   localparam int DIM_DEF     = 8;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } skew_state_t;

   localparam logic MODE_ROW = 1'b0;
   localparam logic MODE_COL = 1'b1;

endpackage

// File: rtl/skew_lane_sel.sv
// Combinational element picker for one skewed output lane: returns the matrix
// element on this lane's diagonal at step k, or zero outside the matrix.
module skew_lane_sel
   import tpu_pkg::*;
#(
   parameter int BITS_AB = BITS_AB_DEF,
   parameter int DIM     = DIM_DEF,
   parameter int CNT_W   = $clog2(2*DIM-1),
   parameter int LANE    = 0
) (
   input  logic [CNT_W-1:0]           k,
   input  logic                       mode,
   input  logic [DIM*DIM*BITS_AB-1:0] m_flat,
   output logic signed [BITS_AB-1:0]  elem
);

   int diag;
   int flat_idx;

   // Lane LANE lags the stream by LANE steps, so it sits at offset k-LANE.
   always_comb begin
      elem     = '0;
      flat_idx = 0;
      diag     = int'(k) - LANE;
      if (diag >= 0 && diag < DIM) begin
         flat_idx = (mode == MODE_COL) ? (diag * DIM + LANE) : (LANE * DIM + diag);
         elem     = m_flat[flat_idx*BITS_AB +: BITS_AB];
      end
   end

endmodule

// File: rtl/systolic_skew_buf.sv
// A-operand staging buffer: stores a DIM x DIM matrix row by row and streams it
// diagonally skewed (row-major or transposed) into the systolic array's left edge.
module systolic_skew_buf
   import tpu_pkg::*;
#(
   parameter  int BITS_AB = BITS_AB_DEF,
   parameter  int DIM     = DIM_DEF,
   localparam int CNT_W   = $clog2(2*DIM-1)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      WrEn,
   input  logic [$clog2(DIM)-1:0]    Arow,
   input  logic signed [BITS_AB-1:0] Ain [DIM-1:0],
   input  logic                      start,
   input  logic                      en,
   input  logic                      transpose,
   output logic signed [BITS_AB-1:0] Aout [DIM-1:0],
   output logic                      Avalid,
   output logic                      busy,
   output logic                      done,
   output logic                      wr_err
);

   localparam int               ROW_W  = $clog2(DIM);
   localparam logic [CNT_W-1:0] K_DONE = CNT_W'(2*DIM-1);

   skew_state_t               state_q, state_d;
   logic [CNT_W-1:0]          k_q, k_d;
   logic                      mode_q, mode_d;
   logic                      avalid_q, avalid_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;
   logic                      wr_err_q, wr_err_d;
   logic signed [BITS_AB-1:0] mem_q [DIM][DIM];
   logic signed [BITS_AB-1:0] mem_d [DIM][DIM];
   logic signed [BITS_AB-1:0] aout_q [DIM];
   logic signed [BITS_AB-1:0] aout_d [DIM];
   logic signed [BITS_AB-1:0] lane_elem [DIM];
   logic [DIM*DIM*BITS_AB-1:0] m_flat;
   logic                      row_ok;

   // Only matters for non-power-of-2 DIM, where Arow can name a missing row.
   assign row_ok = {1'b0, Arow} < (ROW_W+1)'(DIM);

   always_comb begin
      for (int r = 0; r < DIM; r++) begin
         for (int c = 0; c < DIM; c++) begin
            m_flat[(r*DIM+c)*BITS_AB +: BITS_AB] = mem_q[r][c];
         end
      end
   end

   for (genvar i = 0; i < DIM; i++) begin : g_lane
      skew_lane_sel #(
         .BITS_AB (BITS_AB),
         .DIM     (DIM),
         .CNT_W   (CNT_W),
         .LANE    (i)
      ) u_sel (
         .k      (k_q),
         .mode   (mode_q),
         .m_flat (m_flat),
         .elem   (lane_elem[i])
      );
   end

   // NOTE: every _d gets its hold value first, so no path through this block infers a latch.
   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      mode_d   = mode_q;
      avalid_d = avalid_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      wr_err_d = 1'b0;
      mem_d    = mem_q;
      aout_d   = aout_q;
      case (state_q)
         IDLE: begin
            // The write lands on the same edge as the start, so the stream sees it.
            if (WrEn) begin
               if (row_ok) begin
                  for (int c = 0; c < DIM; c++) mem_d[Arow][c] = Ain[c];
               end else begin
                  wr_err_d = 1'b1;
               end
            end
            if (start) begin
               state_d = STREAM;
               mode_d  = transpose;
               k_d     = '0;
               busy_d  = 1'b1;
            end
         end
         STREAM: begin
            wr_err_d = WrEn;
            if (k_q == K_DONE) begin
               state_d  = IDLE;
               k_d      = '0;
               busy_d   = 1'b0;
               done_d   = 1'b1;
               avalid_d = 1'b0;
               for (int i = 0; i < DIM; i++) aout_d[i] = '0;
            end else if (en) begin
               for (int i = 0; i < DIM; i++) aout_d[i] = lane_elem[i];
               avalid_d = 1'b1;
               k_d      = k_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: the storage array is reset too, because a stream after reset must emit zeros.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         k_q      <= '0;
         mode_q   <= MODE_ROW;
         avalid_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         wr_err_q <= 1'b0;
         for (int r = 0; r < DIM; r++) begin
            aout_q[r] <= '0;
            for (int c = 0; c < DIM; c++) mem_q[r][c] <= '0;
         end
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         mode_q   <= mode_d;
         avalid_q <= avalid_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         wr_err_q <= wr_err_d;
         mem_q    <= mem_d;
         aout_q   <= aout_d;
      end
   end

   always_comb begin
      for (int i = 0; i < DIM; i++) Aout[i] = aout_q[i];
   end

   assign Avalid = avalid_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign wr_err = wr_err_q;

endmodule
